sr_dmem_ctrl: RTL

Synchronous, parametrised successor to the combinational `sr_mem` data memory for the schoolRISCV core. It is a byte-addressed, little-endian RAM behind a single-outstanding valid/ready request port with a one-cycle response strobe. It supports byte, half and word loads and stores with sign/zero extension, plus a programmable number of wait states. Misaligned, out-of-range and illegal-size accesses are reported on an error flag instead of corrupting memory. It sits between the core's load/store logic and on-chip data RAM.

---
 rtl/sr_dmem_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sr_dmem_ctrl.sv
// Byte-addressed little-endian data RAM for schoolRISCV with a single-outstanding
// valid/ready request port, programmable wait states and a one-cycle response strobe.
module sr_dmem_ctrl #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is taken on the rising edge where req_valid && req_ready;
    // req_ready depends on state only, the request fields are latched on that edge,
    // and rsp_valid is a single-cycle strobe in RESP with rsp_rdata/rsp_err beside it.

    localparam int WORDS = DEPTH / 4;
    localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        access_fire;
    logic        accept;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_sign;

    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [1:0]  a_size;
    logic        a_sign;
    logic [1:0]  a_span;
    logic [32:0] a_last;
    logic        a_err;
    logic [3:0]  a_be;
    logic [31:0] a_wdata_sh;
    logic [WAW-1:0] a_widx;
    logic [31:0] rd_word;
    logic [31:0] rd_sh;
    logic [31:0] load_data;

    logic [31:0] mem [WORDS];

    assign req_ready = (state == IDLE) || (state == RESP);
    assign rsp_valid = (state == RESP);
    assign dbg_state = state;
    assign accept    = req_valid && req_ready;

    // With zero wait states the access happens on the acceptance edge, so the
    // live request fields are used; otherwise the latched copy is.
    always_comb begin
        if (state == WAIT) begin
            a_we    = lat_we;
            a_addr  = lat_addr;
            a_wdata = lat_wdata;
            a_size  = lat_size;
            a_sign  = lat_sign;
        end else begin
            a_we    = req_we;
            a_addr  = req_addr;
            a_wdata = req_wdata;
            a_size  = req_size;
            a_sign  = req_sign;
        end
    end

    always_comb begin
        a_span = 2'd0;
        a_be   = 4'b0000;
        case (a_size)
            2'b00:   begin a_span = 2'd0; a_be = 4'b0001; end
            2'b01:   begin a_span = 2'd1; a_be = 4'b0011; end
            2'b10:   begin a_span = 2'd3; a_be = 4'b1111; end
            default: begin a_span = 2'd0; a_be = 4'b0000; end
        endcase
        a_be = a_be << a_addr[1:0];
    end

    // End address is computed one bit wider so a high address cannot wrap into range.
    assign a_last = {1'b0, a_addr} + {31'd0, a_span};

    assign a_err = (a_size == 2'b11)
                || ((a_size == 2'b01) && a_addr[0])
                || ((a_size == 2'b10) && (a_addr[1:0] != 2'b00))
                || (a_last >= 33'(DEPTH));

    assign a_widx     = a_addr[WAW+1:2];
    assign a_wdata_sh = a_wdata << {a_addr[1:0], 3'b000};
    assign rd_word    = mem[a_widx];
    assign rd_sh      = rd_word >> {a_addr[1:0], 3'b000};

    always_comb begin
        case (a_size)
            2'b00:   load_data = {{24{a_sign & rd_sh[7]}}, rd_sh[7:0]};
            2'b01:   load_data = {{16{a_sign & rd_sh[15]}}, rd_sh[15:0]};
            default: load_data = rd_sh;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        access_fire  = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        access_fire = 1'b1;
                        state_nxt   = RESP;
                    end else begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = 4'(WAIT_STATES);
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) begin
                    access_fire  = 1'b1;
                    state_nxt    = RESP;
                    wait_cnt_nxt = 4'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_size  <= 2'b00;
            lat_sign  <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_size  <= req_size;
                lat_sign  <= req_sign;
            end
            if (access_fire) begin
                rsp_err   <= a_err;
                rsp_rdata <= (a_err || a_we) ? 32'd0 : load_data;
            end
        end
    end

    // RAM contents are not reset; a store is dropped if reset is high on its access edge.
    always_ff @(posedge clk) begin
        if (access_fire && !rst && !a_err && a_we) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be[i]) begin
                    mem[a_widx][8*i +: 8] <= a_wdata_sh[8*i +: 8];
                end
            end
        end
    end

endmodule
